spi_slave: RTL and testbench

SPI mode-0 responder (the target end of the byte-wide SPI master port): shifts in bytes clocked by an external SPI master, MSB first, and returns a byte to the master on the same clock edges. Sits between the board SPI pins (driven by an external controller such as the config/loader MCU) and the core's internal 8-bit bus. It presents received bytes through a read strobe interface and accepts reply bytes through a write strobe interface. The external SPI signals are asynchronous to `clk`; this block synchronises them and oversamples them.

---
 rtl/spi_slave.sv | 191 +++++++++++++++++++
 tb/tb_spi_slave.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 target: synchronised/oversampled MOSI/SCK/CS, byte RX storage and TX holding register.
// Define SPI_SLAVE_RXFIFO_EN for a 4-entry RX FIFO; otherwise RX storage is a single register.
module spi_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs_n,
  input  logic       spi_clk,
  input  logic       spi_di,
  output logic       spi_do,
  output logic [7:0] rx_dout,
  output logic       rx_avail,
  input  logic       rx_read,
  input  logic [7:0] tx_din,
  input  logic       tx_write,
  output logic       tx_pending,
  output logic       overrun,
  output logic       frame_active
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic            cs_s1, cs_s2;
  logic            sck_s1, sck_s2, sck_prev;
  logic            di_s1, di_s2;
  logic [1:0]      settle;
  logic            armed;
  logic [CW-1:0]   bit_cnt;
  logic [DW-1:0]   rx_shift;
  logic [DW-1:0]   tx_shift;
  logic [DW-1:0]   tx_hold;
  logic            skip_fall;

  logic            sck_rise, sck_fall;
  logic            start, byte_done, reload, pop;
  logic [DW-1:0]   rx_byte;

  // Pin synchronisers plus SCK edge-detect stage
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_prev <= 1'b0;
      di_s1    <= 1'b0;
      di_s2    <= 1'b0;
      settle   <= 2'b00;
    end else begin
      cs_s1    <= spi_cs_n;
      cs_s2    <= cs_s1;
      sck_s1   <= spi_clk;
      sck_s2   <= sck_s1;
      sck_prev <= sck_s2;
      di_s1    <= spi_di;
      di_s2    <= di_s1;
      settle   <= {settle[0], 1'b1};
    end
  end

  assign sck_rise  = sck_s2 & ~sck_prev;
  assign sck_fall  = ~sck_s2 & sck_prev;
  // A frame may only start after CS has genuinely been seen high since reset
  assign start     = (state == IDLE) && armed && !cs_s2;
  assign byte_done = (state == SHIFT) && !cs_s2 && sck_rise && (bit_cnt == CW'(7));
  assign reload    = start || byte_done;
  assign rx_byte   = {rx_shift[6:0], di_s2};
  assign pop       = rx_read && rx_avail;
  assign spi_do    = (state == SHIFT) ? tx_shift[7] : 1'b1;

  // Frame FSM, shift registers and TX holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      armed        <= 1'b0;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= 8'hFF;
      tx_hold      <= '0;
      tx_pending   <= 1'b0;
      skip_fall    <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      frame_active <= ~cs_s2;
      if (settle[1] && cs_s2) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            skip_fall <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_s2) begin
            state <= IDLE;
          end else if (sck_rise) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + CW'(1);
            // Freshly reloaded byte must present its MSB at the next rise
            if (bit_cnt == CW'(7)) skip_fall <= 1'b1;
          end else if (sck_fall) begin
            if (skip_fall) skip_fall <= 1'b0;
            else           tx_shift  <= {tx_shift[6:0], 1'b1};
          end
        end
        default: state <= IDLE;
      endcase

      if (reload) begin
        tx_shift   <= tx_pending ? tx_hold : 8'hFF;
        tx_pending <= 1'b0;
      end
      if (tx_write) begin
        tx_hold    <= tx_din;
        tx_pending <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic          full, push_ok;

  assign full     = (count == 3'(DEPTH));
  assign push_ok  = byte_done && (!full || pop);
  assign rx_avail = (count != 3'd0);
  assign rx_dout  = mem[rd_ptr];

  // RX FIFO: pop applied before push so a same-cycle pop frees the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'hFF;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        overrun <= 1'b0;
      end
      if (push_ok) begin
        mem[wr_ptr] <= rx_byte;
        wr_ptr      <= wr_ptr + PW'(1);
      end else if (byte_done) begin
        overrun <= 1'b1;
      end
      count <= count + 3'(push_ok) - 3'(pop);
    end
  end
`else
  logic [DW-1:0] rx_data;
  logic          rx_valid;

  assign rx_avail = rx_valid;
  assign rx_dout  = rx_data;

  // Single RX holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= 8'hFF;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (pop) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (byte_done) begin
        if (rx_valid && !pop) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= rx_byte;
          rx_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: transaction-level model of RX queue, TX holding register and flags.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_cs_n = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_di = 1'b0;
  logic       spi_do;
  logic [7:0] rx_dout;
  logic       rx_avail;
  logic       rx_read = 1'b0;
  logic [7:0] tx_din = 8'h00;
  logic       tx_write = 1'b0;
  logic       tx_pending;
  logic       overrun;
  logic       frame_active;

`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  spi_slave dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_di(spi_di),
    .spi_do(spi_do), .rx_dout(rx_dout), .rx_avail(rx_avail), .rx_read(rx_read),
    .tx_din(tx_din), .tx_write(tx_write), .tx_pending(tx_pending),
    .overrun(overrun), .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [7:0] q[$];
  bit         m_ov = 0, m_tp = 0, m_frame = 0, mask = 1;
  logic [7:0] m_hold = 8'h00, m_tx = 8'hFF, m_rx = 8'h00, miso_acc = 8'h00;
  int         m_cnt = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of flags/data against the model
  always @(posedge clk) begin
    #2;
    if (!mask) begin
      chk("rx_avail", 8'(rx_avail), 8'(q.size() != 0));
      if (q.size() != 0) chk("rx_dout", rx_dout, q[0]);
      chk("overrun", 8'(overrun), 8'(m_ov));
      chk("tx_pending", 8'(tx_pending), 8'(m_tp));
      chk("frame_active", 8'(frame_active), 8'(m_frame));
      if (!m_frame) chk("spi_do_idle", 8'(spi_do), 8'h01);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reload();
    if (m_tp) begin
      m_tx = m_hold;
      m_tp = 0;
    end else begin
      m_tx = 8'hFF;
    end
  endtask

  task automatic model_pop();
    if (q.size() != 0) begin
      void'(q.pop_front());
      m_ov = 0;
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else                  m_ov = 1;
  endtask

  // Pin changes take effect in the DUT on the third clock; model updates two negedges later
  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(2);
    m_frame = 1;
    m_cnt = 0;
    model_reload();
    tick(3);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    tick(2);
    m_frame = 0;
    tick(3);
  endtask

  task automatic send_bit(input logic b, input bit pop_at_end);
    spi_di = b;
    tick(1);
    chk("miso_bit", 8'(spi_do), 8'(m_tx[3'(7 - m_cnt)]));
    miso_acc = {miso_acc[6:0], spi_do};
    spi_clk = 1'b1;
    tick(2);
    m_rx = {m_rx[6:0], b};
    m_cnt++;
    if (m_cnt == 8) begin
      if (pop_at_end) begin
        rx_read = 1'b1;
        model_pop();
      end
      model_push(m_rx);
      model_reload();
      m_cnt = 0;
    end
    tick(1);
    rx_read = 1'b0;
    tick(1);
    spi_clk = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit pop_last);
    for (int i = 7; i >= 0; i--) send_bit(v[i], pop_last && (i == 0));
  endtask

  task automatic pop();
    rx_read = 1'b1;
    model_pop();
    tick(1);
    rx_read = 1'b0;
  endtask

  task automatic tx_wr(input logic [7:0] v);
    tx_din = v;
    tx_write = 1'b1;
    m_hold = v;
    m_tp = 1;
    tick(1);
    tx_write = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_spi_do"}, 8'(spi_do), 8'h01);
    chk({tag, "_rx_avail"}, 8'(rx_avail), 8'h00);
    chk({tag, "_rx_dout"}, rx_dout, 8'hFF);
    chk({tag, "_overrun"}, 8'(overrun), 8'h00);
    chk({tag, "_tx_pending"}, 8'(tx_pending), 8'h00);
    chk({tag, "_frame_active"}, 8'(frame_active), 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check_reset_values("reset");
    rst = 1'b0;
    tick(3);
    mask = 0;

    // Reply byte returned while receiving one byte
    tx_wr(8'hA5);
    cs_low();
    send_byte(8'h3C, 0);
    chk("t1_miso", miso_acc, 8'hA5);
    cs_high();
    chk("t1_rx_dout", rx_dout, 8'h3C);
    chk("t1_rx_avail", 8'(rx_avail), 8'h01);
    chk("t1_tx_pending", 8'(tx_pending), 8'h00);
    pop();

    // Three back-to-back bytes, no reply written
    cs_low();
    for (int b = 1; b <= 3; b++) begin
      send_byte(8'(b), 0);
      chk("t2_miso", miso_acc, 8'hFF);
    end
    cs_high();
`ifdef SPI_SLAVE_RXFIFO_EN
    chk("t2_pop1", rx_dout, 8'h01);
    pop();
    chk("t2_pop2", rx_dout, 8'h02);
    pop();
    chk("t2_pop3", rx_dout, 8'h03);
    pop();
`else
    chk("t2_rx_dout", rx_dout, 8'h01);
    chk("t2_overrun", 8'(overrun), 8'h01);
    pop();
    tick(1);
    chk("t2_overrun_clr", 8'(overrun), 8'h00);
`endif

    // Partial byte discarded, following byte intact
    cs_low();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    cs_high();
    chk("t3_partial_avail", 8'(rx_avail), 8'h00);
    cs_low();
    send_byte(8'h81, 0);
    cs_high();
    chk("t3_rx_dout", rx_dout, 8'h81);
    pop();

    // Storage full, pop coincides with next byte completion
    cs_low();
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h10 + i), 0);
    chk("t4_full_ov", 8'(overrun), 8'h00);
    send_byte(8'h99, 1);
    cs_high();
    chk("t4_no_overrun", 8'(overrun), 8'h00);
    repeat (DEPTH - 1) pop();
    chk("t4_new_byte", rx_dout, 8'h99);
    pop();

    // Newer reply overwrites older pending one
    tx_wr(8'h11);
    tx_wr(8'h22);
    chk("t5_pending", 8'(tx_pending), 8'h01);
    cs_low();
    send_byte(8'h00, 0);
    chk("t5_miso", miso_acc, 8'h22);
    cs_high();
    pop();

    // Reset mid-byte with data and a pending reply present
    cs_low();
    send_byte(8'hEE, 0);
    tx_wr(8'h77);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    mask = 1;
    rst = 1'b1;
    tick(2);
    check_reset_values("midrst");
    q.delete();
    m_ov = 0;
    m_tp = 0;
    m_frame = 0;
    m_cnt = 0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
      tick(4);
    end
    chk("rst_edges_ignored", 8'(rx_avail), 8'h00);
    cs_high();
    tick(2);
    mask = 0;
    tx_wr(8'h5A);
    cs_low();
    send_byte(8'hC3, 0);
    chk("post_rst_miso", miso_acc, 8'h5A);
    cs_high();
    chk("post_rst_rx", rx_dout, 8'hC3);
    pop();
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
